zuss_alu_sched: RTL and testbench

Shares one ZUSS_ALU instance between two requesters: req0 is the execute stage and req1 is the address/branch unit. It uses round-robin arbitration and a valid/ready handshake on each side. It registers the operands, holds the ALU inputs stable for a per-opcode number of cycles so that mul/div meet timing as multi-cycle paths, and returns one tagged result on a response channel with backpressure. It also screens illegal opcodes and divide-by-zero so those never reach the ALU result path.

---
 rtl/zuss_alu_sched_pkg.sv | 33 +++
 rtl/zuss_alu_sched_if.sv | 48 ++++
 rtl/zuss_alu_sched_rr_arb2.sv | 22 ++
 rtl/zuss_alu_sched.sv | 148 ++++++++++++++
 tb/tb_zuss_alu_sched.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/zuss_alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM states and the
// per-opcode execute-cycle count.
package zuss_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_MUL = 2;
  localparam int unsigned OP_DIV = 3;
  localparam int unsigned OP_OR  = 4;
  localparam int unsigned OP_AND = 5;
  localparam int unsigned OP_NOT = 6;
  localparam int unsigned OP_MOV = 7;
  localparam int unsigned OP_LSL = 8;
  localparam int unsigned OP_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Cycles the ALU inputs must be held before the result is valid.
  function automatic logic [3:0] op_cycles(input int unsigned op,
                                           input logic [3:0]  mul_cycles,
                                           input logic [3:0]  div_cycles);
    logic [3:0] c;
    c = 4'd1;
    if (op == OP_MUL) c = mul_cycles;
    if (op == OP_DIV) c = div_cycles;
    return c;
  endfunction

endpackage

// File: rtl/zuss_alu_sched_if.sv
// Requester, ALU and response signals of the ALU scheduler.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// source holds its payload stable while valid && !ready, ready may depend on valid.
interface zuss_alu_sched_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zr;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_err, busy
  );

endinterface

// File: rtl/zuss_alu_sched_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module zuss_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign grant_id_o = grant_o[1];

endmodule

// File: rtl/zuss_alu_sched.sv
// Shares one external ALU between two requesters: round-robin accept, operands
// held for a per-opcode cycle count, one tagged response with backpressure.
module zuss_alu_sched
  import zuss_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int OPW        = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  zuss_alu_sched_if.slave bus,
  output state_t          dbg_state_o
);

  localparam logic [OPW-1:0] OPC_DIV = OPW'(OP_DIV);
  localparam logic [OPW-1:0] OPC_MAX = OPW'(OP_MAX);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zr_q, rsp_zr_d;
  logic             rsp_err_q, rsp_err_d;
  logic             err_q, err_d;
  logic             err_ones_q, err_ones_d;

  logic [1:0]       grant;
  logic             grant_id;
  logic [OPW-1:0]   op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             illegal;
  logic             div0;
  logic [WIDTH-1:0] cap_data;

  zuss_rr_arb2 u_arb (
    .valid_i      ({bus.req1_valid, bus.req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_id_o   (grant_id)
  );

  assign op_sel  = grant_id ? bus.req1_op : bus.req0_op;
  assign a_sel   = grant_id ? bus.req1_a  : bus.req0_a;
  assign b_sel   = grant_id ? bus.req1_b  : bus.req0_b;
  assign illegal = (op_sel > OPC_MAX);
  assign div0    = (op_sel == OPC_DIV) && (b_sel == '0);

  // Screened ops never look at alu_out: illegal returns 0, div-by-zero all ones.
  assign cap_data = !err_q ? bus.alu_out : (err_ones_q ? '1 : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zr_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      err_q        <= 1'b0;
      err_ones_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zr_q     <= rsp_zr_d;
      rsp_err_q    <= rsp_err_d;
      err_q        <= err_d;
      err_ones_q   <= err_ones_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_zr_d     = rsp_zr_q;
    rsp_err_d    = rsp_err_q;
    err_d        = err_q;
    err_ones_d   = err_ones_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          alu_op_d     = op_sel;
          alu_a_d      = a_sel;
          alu_b_d      = b_sel;
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          err_d        = illegal || div0;
          err_ones_d   = !illegal && div0;
          cnt_d        = (illegal || div0) ? 4'd0
                       : op_cycles(32'(op_sel), 4'(MUL_CYCLES), 4'(DIV_CYCLES)) - 4'd1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_data_d = cap_data;
          rsp_zr_d   = (cap_data == '0);
          rsp_err_d  = err_q;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = rst_n && (state_q == IDLE) && grant[0];
    bus.req1_ready = rst_n && (state_q == IDLE) && grant[1];
    bus.alu_op     = alu_op_q;
    bus.alu_a      = alu_a_q;
    bus.alu_b      = alu_b_q;
    bus.rsp_valid  = (state_q == RESP);
    bus.rsp_id     = rsp_id_q;
    bus.rsp_data   = rsp_data_q;
    bus.rsp_zr     = rsp_zr_q;
    bus.rsp_err    = rsp_err_q;
    bus.busy       = (state_q != IDLE);
    dbg_state_o    = state_q;
  end

endmodule

// File: tb/tb_zuss_alu_sched.sv
// Directed bench for zuss_alu_sched with a behavioural ALU and a response scoreboard.
module tb_zuss_alu_sched;
  import zuss_pkg::*;

  localparam int W = 32;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_errors = 0;
  int     gid;

  // Scoreboard entry: {id, err, zr, data}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] mon_e;

  zuss_alu_sched_if #(.WIDTH(W), .OPW(5)) bus();

  zuss_alu_sched #(
    .WIDTH(W), .OPW(5), .MUL_CYCLES(2), .DIV_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; unknown opcodes produce a non-zero marker value.
  always_comb begin
    case (bus.alu_op)
      5'd0:    bus.alu_out = bus.alu_a + bus.alu_b;
      5'd1:    bus.alu_out = bus.alu_a - bus.alu_b;
      5'd2:    bus.alu_out = bus.alu_a * bus.alu_b;
      5'd3:    bus.alu_out = (bus.alu_b == '0) ? '0 : bus.alu_a / bus.alu_b;
      5'd4:    bus.alu_out = bus.alu_a | bus.alu_b;
      5'd5:    bus.alu_out = bus.alu_a & bus.alu_b;
      5'd6:    bus.alu_out = ~bus.alu_a;
      5'd7:    bus.alu_out = bus.alu_a;
      5'd8:    bus.alu_out = (bus.alu_b >= 32'd32) ? '0 : bus.alu_a << bus.alu_b[4:0];
      default: bus.alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic err, input logic zr, input logic [W-1:0] data);
    exp_q.push_back({id, err, zr, data});
  endtask

  // Response monitor: every handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id",   32'(bus.rsp_id),  32'(mon_e[W+2]));
        check("rsp_err",  32'(bus.rsp_err), 32'(mon_e[W+1]));
        check("rsp_zr",   32'(bus.rsp_zr),  32'(mon_e[W]));
        check("rsp_data", bus.rsp_data,     mon_e[W-1:0]);
      end
    end
  end

  task automatic drive(input int id, input int unsigned op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = 5'(op); bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = 5'(op); bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic release_req(input int id);
    if (id == 0) bus.req0_valid = 1'b0;
    else         bus.req1_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},    32'(dbg_state),     32'(IDLE));
    check({tag, "_ready"},    32'({bus.req1_ready, bus.req0_ready}), 32'(0));
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    check({tag, "_busy"},     32'(bus.busy),      32'(0));
    check({tag, "_rsp_id"},   32'(bus.rsp_id),    32'(0));
    check({tag, "_rsp_data"}, bus.rsp_data,       32'(0));
    check({tag, "_rsp_zr"},   32'(bus.rsp_zr),    32'(0));
    check({tag, "_rsp_err"},  32'(bus.rsp_err),   32'(0));
    check({tag, "_alu_op"},   32'(bus.alu_op),    32'(0));
    check({tag, "_alu_a"},    bus.alu_a,          32'(0));
    check({tag, "_alu_b"},    bus.alu_b,          32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called at a negedge; returns the granted id, or -1 if none within budget.
  task automatic wait_grant(output int id);
    int n;
    n = 0;
    while (!bus.req0_ready && !bus.req1_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", 32'(bus.req0_ready | bus.req1_ready), 32'(1));
    id = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : -1);
  endtask

  // Called just after the accepting edge; counts edges until rsp_valid.
  task automatic wait_rsp(input int exp_c, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 40) begin
      check("exec_alu_a", bus.alu_a, a);
      check("exec_alu_b", bus.alu_b, b);
      check("exec_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'(0));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("rsp_latency", 32'(lat), 32'(exp_c));
  endtask

  // Assumes rsp_ready is high: the handshake completes on the next edge.
  task automatic wait_done();
    @(posedge clk);
    @(negedge clk);
    check("done_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("done_busy",      32'(bus.busy),      32'(0));
  endtask

  task automatic run_op(input int id, input int unsigned op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int c, input logic [W-1:0] data,
                        input logic zr, input logic err);
    int g;
    @(posedge clk);
    #1 drive(id, op, a, b);
    @(negedge clk);
    check("ready_first", 32'(id == 0 ? bus.req0_ready : bus.req1_ready), 32'(1));
    wait_grant(g);
    check("grant_id", 32'(g), 32'(id));
    push_exp(id[0], err, zr, data);
    @(posedge clk);
    #1 release_req(id);
    wait_rsp(c, a, b);
    wait_done();
  endtask

  initial begin
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    do_reset();

    // Single add from req0
    run_op(0, OP_ADD, 32'd5, 32'd7, 1, 32'd12, 1'b0, 1'b0);

    // Both requesters valid back to back: grants alternate starting with req0
    do_reset();
    drive(0, OP_SUB, 32'd9, 32'd9);
    drive(1, OP_OR,  32'd0, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wait_grant(gid);
      check("t2_alt_gnt", 32'(gid), 32'(k % 2));
      push_exp(gid[0], 1'b0, 1'b1, 32'd0);
      @(posedge clk);
      #1;
      if (k == 3) begin
        release_req(0);
        release_req(1);
      end
      if (gid == 0) wait_rsp(1, 32'd9, 32'd9);
      else          wait_rsp(1, 32'd0, 32'd0);
      wait_done();
    end

    // Multi-cycle ops hold operands for their cycle count
    run_op(1, OP_MUL, 32'd6,   32'd7, 2, 32'd42, 1'b0, 1'b0);
    run_op(1, OP_DIV, 32'd100, 32'd7, 8, 32'd14, 1'b0, 1'b0);

    // Screened operations
    run_op(0, OP_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op(0, 12,     32'd3, 32'd4, 1, 32'd0,         1'b1, 1'b1);

    // Backpressure with both requesters pending
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    drive(0, OP_ADD, 32'd1, 32'd2);
    drive(1, OP_AND, 32'hF0, 32'h3C);
    @(negedge clk);
    wait_grant(gid);
    check("t5_tie_gnt", 32'(gid), 32'(1));
    push_exp(1'b1, 1'b0, 1'b0, 32'h30);
    @(posedge clk);
    #1 release_req(1);
    wait_rsp(1, 32'hF0, 32'h3C);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 32'(bus.rsp_valid), 32'(1));
      check("t5_hold_data",  bus.rsp_data,       32'h30);
      check("t5_hold_id",    32'(bus.rsp_id),    32'(1));
      check("t5_hold_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'(0));
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    drive(1, OP_AND, 32'hF0, 32'h3C);
    @(negedge clk);
    check("t5_hs_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'(0));
    wait_grant(gid);
    check("t5_next_gnt", 32'(gid), 32'(0));
    push_exp(1'b0, 1'b0, 1'b0, 32'd3);
    @(posedge clk);
    #1;
    release_req(0);
    release_req(1);
    wait_rsp(1, 32'd1, 32'd2);
    wait_done();

    // Reset in the middle of a divide
    @(posedge clk);
    #1 drive(0, OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    wait_grant(gid);
    check("t6_gnt", 32'(gid), 32'(0));
    @(posedge clk);
    #1 release_req(0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_busy_pre", 32'(bus.busy), 32'(1));
    drive(0, OP_ADD, 32'd1, 32'd1);
    drive(1, OP_ADD, 32'd2, 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    wait_grant(gid);
    check("t6_post_gnt", 32'(gid), 32'(0));
    push_exp(1'b0, 1'b0, 1'b0, 32'd2);
    @(posedge clk);
    #1;
    release_req(0);
    release_req(1);
    wait_rsp(1, 32'd1, 32'd1);
    wait_done();

    repeat (12) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
